// File: rtl/ccu_pkg.sv
// Shared types for the CCU snoop dispatch: ACE snoop channels, monitored core AW/B, snoop FSM states.
// Declarations only; carries no timing or flow-control behaviour of its own.
package ccu_pkg;

    localparam int unsigned AddrW = 64;
    localparam int unsigned DataW = 32;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_CR,
        WAIT_CD
    } snoop_state_e;

    typedef struct packed {
        logic was_unique;
        logic is_shared;
        logic pass_dirty;
        logic error;
        logic data_transfer;
    } cr_resp_t;

    typedef struct packed {
        logic [AddrW-1:0] addr;
        logic [3:0]       snoop;
        logic [2:0]       prot;
    } ac_t;

    typedef struct packed {
        logic [DataW-1:0] data;
        logic             last;
    } cd_t;

    typedef struct packed {
        logic ac_valid;
        ac_t  ac;
        logic cr_ready;
        logic cd_ready;
    } snoop_req_t;

    typedef struct packed {
        logic     ac_ready;
        logic     cr_valid;
        cr_resp_t cr_resp;
        logic     cd_valid;
        cd_t      cd;
    } snoop_resp_t;

    typedef struct packed {
        logic             aw_valid;
        logic [AddrW-1:0] aw_addr;
        logic             b_ready;
    } req_t;

    typedef struct packed {
        logic aw_ready;
        logic b_valid;
    } resp_t;

    function automatic logic [AddrW-1:0] line_addr(input logic [AddrW-1:0] addr,
                                                   input int unsigned      off_bits);
        return addr >> off_bits;
    endfunction

endpackage

// File: rtl/ccu_wr_line_tracker.sv
// Circular buffer of cache lines a core still has writes open on (AW..B), with combinational lookup.
// Lookup is zero latency; push/pop land next cycle. Push into a full buffer without a same-cycle pop is dropped.
module ccu_wr_line_tracker #(
    parameter int unsigned LineWidth = 64,
    parameter int unsigned Depth     = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 push_i,
    input  logic [LineWidth-1:0] push_line_i,
    input  logic                 pop_i,
    input  logic [LineWidth-1:0] lookup_line_i,
    output logic                 hit_o,
    output logic                 full_o,
    output logic                 empty_o
);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [LineWidth-1:0] line_q [Depth];
    logic [LineWidth-1:0] line_d [Depth];
    logic [Depth-1:0]     vld_q, vld_d;
    logic [PtrW-1:0]      head_q, head_d, tail_q, tail_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 do_push, do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);
    assign do_pop  = pop_i & ~empty_o;
    // A pop frees the head slot this cycle, so a full buffer can still take a push.
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        line_d = line_q;
        vld_d  = vld_q;
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        if (do_pop) begin
            vld_d[head_q] = 1'b0;
            head_d        = ptr_inc(head_q);
        end
        if (do_push) begin
            vld_d[tail_q]  = 1'b1;
            line_d[tail_q] = push_line_i;
            tail_d         = ptr_inc(tail_q);
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Uses the registered valid bits, so an entry popped this cycle still reports a hit.
    always_comb begin
        hit_o = 1'b0;
        for (int i = 0; i < Depth; i++) begin
            if (vld_q[i] && (line_q[i] == lookup_line_i)) hit_o = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            vld_q  <= '0;
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            line_q <= line_d;
            vld_q  <= vld_d;
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
            assert (!(push_i && full_o && !pop_i));
            assert (!(pop_i && empty_o));
        end
    end

endmodule

// File: rtl/ccu_snoop_dispatch.sv
// Per-port snoop dispatch: forwards AC/CR/CD, keeps one snoop open per port, holds AC off lines with writes in flight.
// Zero latency pass-through; only ac_valid/ac_ready are gated, both forced low while blocked, busy or in reset.
module ccu_snoop_dispatch import ccu_pkg::*; #(
    parameter int unsigned NoPorts      = 4,
    parameter int unsigned AxiAddrWidth = 64,
    parameter int unsigned LineBytes    = 16,
    parameter int unsigned MaxOutWr     = 4,
    parameter type         req_t        = ccu_pkg::req_t,
    parameter type         resp_t       = ccu_pkg::resp_t,
    parameter type         snoop_req_t  = ccu_pkg::snoop_req_t,
    parameter type         snoop_resp_t = ccu_pkg::snoop_resp_t
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  snoop_req_t  [NoPorts-1:0] ccu_snoop_req_i,
    output snoop_resp_t [NoPorts-1:0] ccu_snoop_resp_o,
    output snoop_req_t  [NoPorts-1:0] core_snoop_req_o,
    input  snoop_resp_t [NoPorts-1:0] core_snoop_resp_i,
    input  req_t        [NoPorts-1:0] core_req_i,
    input  resp_t       [NoPorts-1:0] core_resp_i
);
    localparam int unsigned LineOff = $clog2(LineBytes);

    for (genvar p = 0; p < NoPorts; p++) begin : g_port
        snoop_state_e            state_q, state_d;
        logic [AxiAddrWidth-1:0] ac_line, aw_line;
        logic                    aw_hs, b_hs, ac_hs, cr_hs, cd_hs;
        logic                    hit, blk, ac_open;
        logic                    full, empty, trk_unused;
        snoop_req_t              core_req_s;
        snoop_resp_t             ccu_resp_s;

        assign ac_line = line_addr(ccu_snoop_req_i[p].ac.addr, LineOff);
        assign aw_line = line_addr(core_req_i[p].aw_addr, LineOff);

        assign aw_hs = core_req_i[p].aw_valid & core_resp_i[p].aw_ready;
        assign b_hs  = core_resp_i[p].b_valid & core_req_i[p].b_ready;
        assign cr_hs = core_snoop_resp_i[p].cr_valid & ccu_snoop_req_i[p].cr_ready;
        assign cd_hs = core_snoop_resp_i[p].cd_valid & ccu_snoop_req_i[p].cd_ready;

        // A write being accepted this very cycle wins over a snoop to the same line.
        assign blk     = hit | (aw_hs & (aw_line == ac_line));
        assign ac_open = rst_ni & (state_q == IDLE) & ~blk;
        assign ac_hs   = ccu_snoop_req_i[p].ac_valid & core_snoop_resp_i[p].ac_ready & ac_open;

        ccu_wr_line_tracker #(
            .LineWidth (AxiAddrWidth),
            .Depth     (MaxOutWr)
        ) i_tracker (
            .clk_i         (clk_i),
            .rst_ni        (rst_ni),
            .push_i        (aw_hs),
            .push_line_i   (aw_line),
            .pop_i         (b_hs),
            .lookup_line_i (ac_line),
            .hit_o         (hit),
            .full_o        (full),
            .empty_o       (empty)
        );
        assign trk_unused = full ^ empty;

        always_comb begin
            core_req_s          = ccu_snoop_req_i[p];
            core_req_s.ac_valid = ccu_snoop_req_i[p].ac_valid & ac_open;
            ccu_resp_s          = core_snoop_resp_i[p];
            ccu_resp_s.ac_ready = core_snoop_resp_i[p].ac_ready & ac_open;
        end
        assign core_snoop_req_o[p] = core_req_s;
        assign ccu_snoop_resp_o[p] = ccu_resp_s;

        always_comb begin
            state_d = state_q;
            unique case (state_q)
                IDLE:    if (ac_hs) state_d = WAIT_CR;
                WAIT_CR: if (cr_hs) state_d = core_snoop_resp_i[p].cr_resp.data_transfer ? WAIT_CD : IDLE;
                WAIT_CD: if (cd_hs && core_snoop_resp_i[p].cd.last) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                state_q <= IDLE;
            end else begin
                state_q <= state_d;
                if (state_q == IDLE) begin
                    assert (!core_snoop_resp_i[p].cr_valid && !core_snoop_resp_i[p].cd_valid);
                end
            end
        end
    end

endmodule

// File: tb/tb_ccu_snoop_dispatch.sv
// Bench for ccu_snoop_dispatch: directed scenarios with literal expectations, then randomized legal traffic
// checked every cycle against a queue-based model of open snoops and in-flight write lines.
module tb_ccu_snoop_dispatch;
    import ccu_pkg::*;

    localparam int NP = 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    snoop_req_t  [NP-1:0] ccu_req, core_sreq;
    snoop_resp_t [NP-1:0] ccu_resp, core_sresp;
    req_t        [NP-1:0] core_req;
    resp_t       [NP-1:0] core_resp;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: phase 0 = no snoop open, 1 = awaiting CR, 2 = awaiting last CD beat.
    int          phase [NP] = '{default: 0};
    logic [63:0] wrq [NP][$];

    always #5 clk = ~clk;

    ccu_snoop_dispatch #(
        .NoPorts      (NP),
        .AxiAddrWidth (64),
        .LineBytes    (16),
        .MaxOutWr     (4)
    ) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .ccu_snoop_req_i   (ccu_req),
        .ccu_snoop_resp_o  (ccu_resp),
        .core_snoop_req_o  (core_sreq),
        .core_snoop_resp_i (core_sresp),
        .core_req_i        (core_req),
        .core_resp_i       (core_resp)
    );

    task automatic chk(input string name, input int p, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s port%0d: got %0h, expected %0h (t=%0t)", name, p, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, then the model advances on this cycle's inputs.
    always @(negedge clk) begin
        for (int p = 0; p < NP; p++) begin : cmp
            logic [63:0] acl;
            logic        aw_hs, b_hs, blk, can;
            snoop_req_t  ereq;
            snoop_resp_t eresp;
            acl   = ccu_req[p].ac.addr >> 4;
            aw_hs = core_req[p].aw_valid && core_resp[p].aw_ready;
            b_hs  = core_resp[p].b_valid && core_req[p].b_ready;
            blk   = 1'b0;
            for (int i = 0; i < wrq[p].size(); i++) if (wrq[p][i] == acl) blk = 1'b1;
            if (aw_hs && ((core_req[p].aw_addr >> 4) == acl)) blk = 1'b1;
            can = rst_n && (phase[p] == 0) && !blk;
            ereq           = ccu_req[p];
            ereq.ac_valid  = ccu_req[p].ac_valid && can;
            eresp          = core_sresp[p];
            eresp.ac_ready = core_sresp[p].ac_ready && can;
            chk("model_core_snoop_req", p, 128'(core_sreq[p]), 128'(ereq));
            chk("model_ccu_snoop_resp", p, 128'(ccu_resp[p]), 128'(eresp));
            if (!rst_n) begin
                phase[p] = 0;
                wrq[p].delete();
            end else begin
                case (phase[p])
                    0: if (ccu_req[p].ac_valid && core_sresp[p].ac_ready && can) phase[p] = 1;
                    1: if (core_sresp[p].cr_valid && ccu_req[p].cr_ready)
                           phase[p] = core_sresp[p].cr_resp.data_transfer ? 2 : 0;
                    2: if (core_sresp[p].cd_valid && ccu_req[p].cd_ready && core_sresp[p].cd.last) phase[p] = 0;
                    default: phase[p] = 0;
                endcase
                if (b_hs) void'(wrq[p].pop_front());
                if (aw_hs) wrq[p].push_back(core_req[p].aw_addr >> 4);
            end
        end
    end

    function automatic logic coin(input int unsigned pct);
        return ($urandom_range(99) < pct);
    endfunction

    task automatic clr();
        ccu_req    = '0;
        core_sresp = '0;
        core_req   = '0;
        core_resp  = '0;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
        clr();
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic do_ac(input int p, input logic [63:0] a);
        ccu_req[p].ac_valid    = 1'b1;
        ccu_req[p].ac.addr     = a;
        core_sresp[p].ac_ready = 1'b1;
    endtask

    task automatic do_cr(input int p, input logic dt);
        core_sresp[p].cr_valid              = 1'b1;
        core_sresp[p].cr_resp.data_transfer = dt;
        ccu_req[p].cr_ready                 = 1'b1;
    endtask

    task automatic do_cd(input int p, input logic last);
        core_sresp[p].cd_valid = 1'b1;
        core_sresp[p].cd.last  = last;
        core_sresp[p].cd.data  = 32'hcafe_0000 | 32'(last);
        ccu_req[p].cd_ready    = 1'b1;
    endtask

    task automatic do_aw(input int p, input logic [63:0] a);
        core_req[p].aw_valid  = 1'b1;
        core_req[p].aw_addr   = a;
        core_resp[p].aw_ready = 1'b1;
    endtask

    task automatic do_b(input int p);
        core_resp[p].b_valid = 1'b1;
        core_req[p].b_ready  = 1'b1;
    endtask

    task automatic expect_ac(input string name, input int p, input logic e);
        chk({name, "_core_ac_valid"}, p, 128'(core_sreq[p].ac_valid), 128'(e));
        chk({name, "_ccu_ac_ready"}, p, 128'(ccu_resp[p].ac_ready), 128'(e));
    endtask

    initial begin
        clr();
        rst_n = 1'b0;
        for (int p = 0; p < NP; p++) do_ac(p, 64'h1000);
        smp();
        for (int p = 0; p < NP; p++) expect_ac("reset_gate", p, 1'b0);
        nxt();
        rst_n = 1'b1;

        // Plain snoop, CR without data, back-to-back acceptance.
        nxt(); do_ac(0, 64'h1000); smp(); expect_ac("t1_forward", 0, 1'b1);
        nxt(); do_ac(0, 64'h1040); do_cr(0, 1'b0); smp(); expect_ac("t1_wait_cr", 0, 1'b0);
        chk("t1_cr_pass", 0, 128'(ccu_resp[0].cr_valid), 128'(1));
        nxt(); do_ac(0, 64'h1040); smp(); expect_ac("t1_next_ac", 0, 1'b1);
        nxt(); do_cr(0, 1'b0);

        // Write in flight to the same line blocks until the cycle after B.
        nxt(); do_aw(0, 64'h1008);
        nxt(); do_ac(0, 64'h1000); smp(); expect_ac("t2_blocked", 0, 1'b0);
        nxt(); do_ac(0, 64'h1000); do_b(0); smp(); expect_ac("t2_b_cycle", 0, 1'b0);
        nxt(); do_ac(0, 64'h1000); smp(); expect_ac("t2_after_b", 0, 1'b1);
        nxt(); do_cr(0, 1'b0);

        // Data-carrying snoop: stays closed through the CD burst.
        nxt(); do_ac(0, 64'h2000); smp(); expect_ac("t3_forward", 0, 1'b1);
        nxt(); do_ac(0, 64'h2000); do_cr(0, 1'b1); smp(); expect_ac("t3_wait_cr", 0, 1'b0);
        nxt(); do_ac(0, 64'h2000); do_cd(0, 1'b0); smp(); expect_ac("t3_cd_beat0", 0, 1'b0);
        chk("t3_cd_data", 0, 128'(ccu_resp[0].cd.data), 128'(32'hcafe_0000));
        nxt(); do_ac(0, 64'h2000); do_cd(0, 1'b1); smp(); expect_ac("t3_cd_last", 0, 1'b0);
        nxt(); do_ac(0, 64'h2000); smp(); expect_ac("t3_idle_again", 0, 1'b1);
        nxt(); do_cr(0, 1'b0);

        // Same-cycle AW beats AC on its own port only.
        nxt(); do_aw(1, 64'h3000); do_ac(1, 64'h3000); do_ac(2, 64'h3000); smp();
        expect_ac("t4_same_cycle_aw", 1, 1'b0);
        expect_ac("t4_other_port", 2, 1'b1);
        nxt(); do_b(1); do_cr(2, 1'b0); do_ac(1, 64'h300c); smp(); expect_ac("t4_tracked", 1, 1'b0);

        // Full tracker, push+pop together, pointer wrap.
        for (int i = 0; i < 4; i++) begin
            nxt(); do_aw(3, 64'h4000 + 64'(i) * 64'd16);
        end
        nxt(); do_b(3); do_aw(3, 64'h4040); do_ac(3, 64'h4000); smp(); expect_ac("t5_pop_blocks", 3, 1'b0);
        nxt(); do_ac(3, 64'h4044); smp(); expect_ac("t5_new_tail", 3, 1'b0);
        nxt(); do_ac(3, 64'h4010); smp(); expect_ac("t5_old_entry", 3, 1'b0);
        nxt(); do_ac(3, 64'h4000); smp(); expect_ac("t5_popped_line", 3, 1'b1);
        nxt(); do_cr(3, 1'b0); do_b(3); do_aw(3, 64'h4050);
        nxt(); do_ac(3, 64'h4010); smp(); expect_ac("t5_second_pop", 3, 1'b1);
        nxt(); do_cr(3, 1'b0);
        nxt(); do_ac(3, 64'h4050); smp(); expect_ac("t5_wrapped_entry", 3, 1'b0);
        for (int i = 0; i < 4; i++) begin
            nxt(); do_b(3);
        end
        nxt(); do_ac(3, 64'h4050); smp(); expect_ac("t5_drained", 3, 1'b1);
        nxt(); do_cr(3, 1'b0);

        // Reset in the middle of a CD burst with a write outstanding.
        nxt(); do_ac(0, 64'h5000);
        nxt(); do_cr(0, 1'b1); do_aw(0, 64'h5000);
        nxt(); do_cd(0, 1'b0);
        nxt(); rst_n = 1'b0; do_ac(0, 64'h5000); smp(); expect_ac("t6_in_reset", 0, 1'b0);
        nxt(); rst_n = 1'b1; do_ac(0, 64'h5000); smp(); expect_ac("t6_after_reset", 0, 1'b1);
        nxt(); do_cr(0, 1'b0);

        // Randomized legal traffic on all ports.
        for (int c = 0; c < 3000; c++) begin
            nxt();
            rst_n = ($urandom_range(299) != 0);
            for (int p = 0; p < NP; p++) begin : drv
                logic b_hs;
                if (phase[p] != 0) begin
                    ccu_req[p].ac_valid    = 1'b1;
                    ccu_req[p].ac.addr     = 64'h9000 + 64'($urandom_range(255));
                    core_sresp[p].ac_ready = 1'b1;
                end else begin
                    ccu_req[p].ac_valid    = coin(70);
                    ccu_req[p].ac.addr     = 64'h1000 + 64'($urandom_range(3)) * 64'd16 + 64'($urandom_range(15));
                    core_sresp[p].ac_ready = coin(70);
                end
                ccu_req[p].ac.snoop     = 4'($urandom);
                ccu_req[p].ac.prot      = 3'($urandom);
                ccu_req[p].cr_ready     = coin(60);
                ccu_req[p].cd_ready     = coin(60);
                core_sresp[p].cr_valid  = (phase[p] == 1) && coin(50);
                core_sresp[p].cr_resp   = 5'($urandom);
                core_sresp[p].cd_valid  = (phase[p] == 2) && coin(50);
                core_sresp[p].cd.data   = 32'($urandom);
                core_sresp[p].cd.last   = coin(35);
                core_resp[p].b_valid    = (wrq[p].size() > 0) && coin(40);
                core_req[p].b_ready     = coin(70);
                b_hs                    = core_resp[p].b_valid && core_req[p].b_ready;
                core_req[p].aw_valid    = coin(50);
                core_req[p].aw_addr     = 64'h1000 + 64'($urandom_range(3)) * 64'd16 + 64'($urandom_range(15));
                core_resp[p].aw_ready   = ((wrq[p].size() < 4) || b_hs) && coin(60);
            end
        end

        nxt();
        rst_n = 1'b1;
        smp();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
